// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the accumulator front-end.
//   ADD_WIDTH : default datapath width of the adder and accumulator
//   state_e   : control FSM states
//   ovf()     : signed-overflow detect from operand and result sign bits
package adder_pkg;

   localparam int unsigned ADD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Two's-complement overflow: both operands share a sign and the result does not.
   function automatic logic ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/PlusOperatorAdder.sv
// PlusOperatorAdder: combinational WIDTH-bit adder with carry in/out.
//   A, B : operands
//   Cin  : carry in
//   Sum  : A + B + Cin modulo 2^WIDTH
//   Cout : carry out of the top bit
module PlusOperatorAdder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};

endmodule

// File: rtl/adder_accumulator_seq.sv
// adder_accumulator_seq: streams signed samples through PlusOperatorAdder and
// returns the running sum of a job with sticky carry and signed-overflow flags.
//   clk, rst            : clock and synchronous active-high reset
//   start, len          : job request (sampled in IDLE) and sample count
//   in_valid, in_data   : sample stream; in_ready high while accumulating
//   out_valid/out_ready : result handshake; out_sum, out_cout, out_ovf result
//   busy                : high whenever a job is in flight or awaiting pickup
module adder_accumulator_seq
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = ADD_WIDTH,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   state_e state_q, state_d;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             in_hs;

   // Datapath: the adder always sees acc + in_data; results are only committed on a handshake.
   PlusOperatorAdder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .A    (acc_q),
      .B    (in_data),
      .Cin  (1'b0),
      .Sum  (sum),
      .Cout (cout)
   );

   assign in_hs = in_valid && in_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_hs && (rem_q == LEN_W'(1))) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state; result fields always show the held registers.
   always_comb begin
      in_ready  = (state_q == ACCUM);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      out_sum   = acc_q;
      out_cout  = cout_q;
      out_ovf   = ovf_q;
   end

   // Accumulator, sample counter and sticky flags.
   always_comb begin
      acc_d  = acc_q;
      rem_d  = rem_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      if ((state_q == IDLE) && start) begin
         acc_d  = '0;
         rem_d  = len;
         cout_d = 1'b0;
         ovf_d  = 1'b0;
      end else if (in_hs) begin
         acc_d  = sum;
         rem_d  = rem_q - LEN_W'(1);
         cout_d = cout_q | cout;
         ovf_d  = ovf_q | ovf(acc_q[WIDTH-1], in_data[WIDTH-1], sum[WIDTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         rem_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         rem_q  <= rem_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule

// File: tb/tb_adder_accumulator_seq.sv
module tb_adder_accumulator_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic        busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   adder_accumulator_seq #(
      .WIDTH (32),
      .LEN_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: true integer arithmetic per sample; carry from the unsigned view,
   // overflow whenever the exact signed sum leaves the 32-bit range.
   function automatic void model(input logic [31:0] s[$], output logic [31:0] sum,
                                 output logic c, output logic o);
      logic [31:0] a = 32'd0;
      longint      t;
      longint      u;
      c = 1'b0;
      o = 1'b0;
      foreach (s[i]) begin
         u = longint'({32'd0, a}) + longint'({32'd0, s[i]});
         if (u > 64'sd4294967295) c = 1'b1;
         t = longint'($signed(a)) + longint'($signed(s[i]));
         if ((t > 64'sd2147483647) || (t < -64'sd2147483648)) o = 1'b1;
         a = a + s[i];
      end
      sum = a;
   endfunction

   // Drives one job; spur holds start high with len=5 while the block is accumulating.
   task automatic send_job(input int n, input logic [31:0] s[$], input int gap,
                           input bit spur, output bit timed_out);
      int w;
      timed_out = 1'b0;
      start = 1'b1;
      len   = n[7:0];
      step();
      start = 1'b0;
      foreach (s[i]) begin
         repeat (gap) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            if (spur) begin start = 1'b1; len = 8'd5; end
            step();
         end
         in_valid = 1'b1;
         in_data  = s[i];
         if (spur) begin start = 1'b1; len = 8'd5; end
         w = 0;
         while (!in_ready && w < 20) begin step(); w++; end
         if (w >= 20) timed_out = 1'b1;
         step();
         in_valid = 1'b0;
         in_data  = $urandom;
      end
      start = 1'b0;
      len   = 8'd0;
   endtask

   // Waits stall cycles with out_ready low, tracking whether the result held, then accepts.
   task automatic collect(input int stall, output logic [31:0] s, output logic c,
                          output logic o, output bit stable);
      s = out_sum;
      c = out_cout;
      o = out_ovf;
      stable = 1'b1;
      out_ready = 1'b0;
      repeat (stall) begin
         step();
         if (out_valid !== 1'b1 || out_sum !== s || out_cout !== c || out_ovf !== o)
            stable = 1'b0;
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total_cnt++;
      if ({in_ready, out_valid, busy, out_cout, out_ovf} !== 5'b0 || out_sum !== 32'd0)
         $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b sum=%h c=%b o=%b, want all 0",
                  in_ready, out_valid, busy, out_sum, out_cout, out_ovf);
      else pass_cnt++;
      rst = 1'b0;
      step();
      total_cnt++;
      if (busy !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL idle_after_reset: got busy=%b rdy=%b, want 0 0", busy, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_mixed();
      logic [31:0] q[$];
      logic [31:0] es, gs;
      logic ec, eo, gc, go;
      bit to, st;
      q = '{32'd100, -32'sd200, 32'd50};
      model(q, es, ec, eo);
      send_job(3, q, 0, 1'b0, to);
      total_cnt++;
      if (to || out_valid !== 1'b1)
         $display("FAIL mixed_latency: got out_valid=%b timeout=%0d, want 1 0", out_valid, to);
      else pass_cnt++;
      collect(0, gs, gc, go, st);
      total_cnt++;
      if (gs !== 32'hFFFF_FFCE || gc !== 1'b0 || go !== 1'b0 || es !== 32'hFFFF_FFCE)
         $display("FAIL mixed_result: got %h c=%b o=%b, want FFFFFFCE 0 0", gs, gc, go);
      else pass_cnt++;
      step();
   endtask

   task automatic test_sticky();
      logic [31:0] q[$];
      logic [31:0] gs;
      logic gc, go;
      bit to, st;
      q = '{32'h7FFF_FFFF, 32'd1};
      send_job(2, q, 0, 1'b0, to);
      collect(1, gs, gc, go, st);
      total_cnt++;
      if (to || gs !== 32'h8000_0000 || go !== 1'b1 || gc !== 1'b0)
         $display("FAIL sticky_job1: got %h c=%b o=%b, want 80000000 0 1", gs, gc, go);
      else pass_cnt++;
      step();
      q = '{32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF};
      send_job(3, q, 0, 1'b0, to);
      collect(0, gs, gc, go, st);
      total_cnt++;
      if (to || gs !== 32'h7FFF_FFFF || go !== 1'b1 || gc !== 1'b1)
         $display("FAIL sticky_job2: got %h c=%b o=%b, want 7FFFFFFF 1 1", gs, gc, go);
      else pass_cnt++;
      step();
   endtask

   task automatic test_zero_len();
      logic [31:0] gs;
      logic gc, go;
      bit st;
      in_valid = 1'b1;
      in_data  = 32'd99;
      start = 1'b1;
      len   = 8'd0;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL zero_idle_ready: got %b, want 0", in_ready);
      else pass_cnt++;
      step();
      start = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL zero_latency: got vld=%b rdy=%b, want 1 0", out_valid, in_ready);
      else pass_cnt++;
      collect(0, gs, gc, go, st);
      in_valid = 1'b0;
      total_cnt++;
      if (gs !== 32'd0 || gc !== 1'b0 || go !== 1'b0)
         $display("FAIL zero_result: got %h c=%b o=%b, want 0 0 0", gs, gc, go);
      else pass_cnt++;
      step();
   endtask

   task automatic test_backpressure();
      logic [31:0] q[$];
      logic [31:0] gs;
      logic gc, go;
      bit to, st;
      q = '{32'd1, 32'd2, 32'd3, 32'd4};
      send_job(4, q, 3, 1'b0, to);
      total_cnt++;
      if (to || out_valid !== 1'b1)
         $display("FAIL bp_latency: got out_valid=%b timeout=%0d, want 1 0", out_valid, to);
      else pass_cnt++;
      collect(5, gs, gc, go, st);
      total_cnt++;
      if (!st || gs !== 32'd10 || gc !== 1'b0 || go !== 1'b0)
         $display("FAIL bp_result: got %h c=%b o=%b stable=%0d, want 0000000a 0 0 1",
                  gs, gc, go, st);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'd10)
         $display("FAIL bp_idle: got busy=%b vld=%b sum=%h, want 0 0 0000000a",
                  busy, out_valid, out_sum);
      else pass_cnt++;
      step();
   endtask

   task automatic test_ignored_start();
      logic [31:0] q[$];
      logic [31:0] gs;
      logic gc, go;
      bit to, st;
      q = '{32'd5, 32'd6, 32'd7};
      send_job(3, q, 1, 1'b1, to);
      total_cnt++;
      if (to || out_valid !== 1'b1 || busy !== 1'b1)
         $display("FAIL ign_accum: got vld=%b busy=%b, want 1 1", out_valid, busy);
      else pass_cnt++;
      start = 1'b1;
      len   = 8'd5;
      collect(2, gs, gc, go, st);
      total_cnt++;
      if (!st || gs !== 32'd18)
         $display("FAIL ign_done: got %h stable=%0d, want 00000012 1", gs, st);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL ign_accept_cycle: got busy=%b rdy=%b, want 0 0", busy, in_ready);
      else pass_cnt++;
      start = 1'b0;
      len   = 8'd0;
      step();
   endtask

   task automatic test_reset_mid_job();
      logic [31:0] q[$];
      logic [31:0] gs;
      logic gc, go;
      bit to, st;
      start = 1'b1;
      len   = 8'd4;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h7FFF_FFFF;
      step();
      in_data  = 32'h7FFF_FFFF;
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'd0 ||
          out_ovf !== 1'b0)
         $display("FAIL midrst_idle: got busy=%b rdy=%b vld=%b sum=%h o=%b, want 0 0 0 0 0",
                  busy, in_ready, out_valid, out_sum, out_ovf);
      else pass_cnt++;
      q = '{32'd7};
      send_job(1, q, 0, 1'b0, to);
      collect(0, gs, gc, go, st);
      total_cnt++;
      if (to || gs !== 32'd7 || gc !== 1'b0 || go !== 1'b0)
         $display("FAIL midrst_next: got %h c=%b o=%b, want 00000007 0 0", gs, gc, go);
      else pass_cnt++;
      step();
   endtask

   task automatic test_random();
      logic [31:0] q[$];
      logic [31:0] es, gs;
      logic ec, eo, gc, go;
      bit to, st;
      int n;
      for (int j = 0; j < 25; j++) begin
         q.delete();
         n = $urandom_range(0, 8);
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 3))
               0: q.push_back(32'h7FFF_0000 + $urandom_range(0, 32'hFFFF));
               1: q.push_back(32'h8000_0000 + $urandom_range(0, 32'hFFFF));
               default: q.push_back($urandom);
            endcase
         end
         model(q, es, ec, eo);
         send_job(n, q, $urandom_range(0, 2), 1'b0, to);
         total_cnt++;
         if (to || out_valid !== 1'b1)
            $display("FAIL rand_latency[%0d]: got vld=%b timeout=%0d, want 1 0", j, out_valid, to);
         else pass_cnt++;
         collect($urandom_range(0, 3), gs, gc, go, st);
         total_cnt++;
         if (!st || gs !== es || gc !== ec || go !== eo)
            $display("FAIL rand_result[%0d]: got %h c=%b o=%b stable=%0d, want %h %b %b 1",
                     j, gs, gc, go, st, es, ec, eo);
         else pass_cnt++;
         step();
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      len       = 8'd0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      out_ready = 1'b0;
      test_reset();
      test_mixed();
      test_sticky();
      test_zero_len();
      test_backpressure();
      test_ignored_start();
      test_reset_mid_job();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
